// File: rtl/strand_issue_arbiter.sv
// ============================================================================
// Module   : strand_issue_arbiter
// Purpose  : Four-strand round-robin issue arbiter with per-strand run state
//            (running / suspended on miss / rollback recovery).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module strand_issue_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] if_instruction_valid,
    input  logic [3:0] execute_hazard,
    input  logic [3:0] strand_enable,
    input  logic       stall,
    input  logic [3:0] suspend_strand,
    input  logic [3:0] resume_strand,
    input  logic [3:0] rollback_strand,
    output logic [3:0] issue_oh,
    output logic [3:0] strand_running,
    output logic       all_blocked
);

    localparam logic [1:0] ST_RUNNING   = 2'd0;
    localparam logic [1:0] ST_SUSPENDED = 2'd1;
    localparam logic [1:0] ST_RB_WAIT   = 2'd2;

    logic [1:0] state      [4];
    logic [1:0] state_nxt  [4];
    logic       rb_cnt     [4];
    logic       rb_cnt_nxt [4];
    logic [3:0] eligible;
    logic [1:0] last_grant;
    logic [1:0] grant_idx;

    generate
        for (genvar n = 0; n < 4; n++) begin : g_strand
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state[n]  <= ST_RUNNING;
                    rb_cnt[n] <= 1'b0;
                end else begin
                    state[n]  <= state_nxt[n];
                    rb_cnt[n] <= rb_cnt_nxt[n];
                end
            end

            // Rollback dominates every other request, including one already in RB_WAIT.
            always_comb begin
                state_nxt[n]  = state[n];
                rb_cnt_nxt[n] = rb_cnt[n];
                if (rollback_strand[n]) begin
                    state_nxt[n]  = ST_RB_WAIT;
                    rb_cnt_nxt[n] = 1'b1;
                end else begin
                    case (state[n])
                        ST_RUNNING: begin
                            if (suspend_strand[n] && !resume_strand[n])
                                state_nxt[n] = ST_SUSPENDED;
                        end
                        ST_SUSPENDED: begin
                            if (resume_strand[n])
                                state_nxt[n] = ST_RUNNING;
                        end
                        ST_RB_WAIT: begin
                            if (rb_cnt[n])
                                rb_cnt_nxt[n] = 1'b0;
                            else
                                state_nxt[n] = ST_RUNNING;
                        end
                        default: state_nxt[n] = ST_RUNNING;
                    endcase
                end
            end

            always_comb begin
                strand_running[n] = (state[n] == ST_RUNNING);
                eligible[n] = (state[n] == ST_RUNNING) && if_instruction_valid[n] &&
                              strand_enable[n] && !execute_hazard[n] && !rollback_strand[n];
            end
        end
    endgenerate

    // Search starts one past the last winner; the 2-bit sum wraps naturally.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found     = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        issue_oh = 4'b0000;
        if (found && !stall)
            issue_oh[grant_idx] = 1'b1;
        all_blocked = (eligible == 4'b0000) && !stall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= 2'd3;
        else if (issue_oh != 4'b0000)
            last_grant <= grant_idx;
    end

endmodule

`default_nettype wire

// File: tb/tb_strand_issue_arbiter.sv
// ============================================================================
// Module   : tb_strand_issue_arbiter
// Purpose  : Directed bench for strand_issue_arbiter with a cycle-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_strand_issue_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] valid, hazard, enable, suspend, resume, rollback;
    logic       stall;
    logic [3:0] issue_oh, strand_running;
    logic       all_blocked;

    int checks   = 0;
    int failures = 0;

    // Model: suspended flag, cycles of rollback blocking left, last winner.
    bit m_susp [4];
    int m_rb   [4];
    int m_lg;

    always #5 clk = ~clk;

    strand_issue_arbiter dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .if_instruction_valid (valid),
        .execute_hazard       (hazard),
        .strand_enable        (enable),
        .stall                (stall),
        .suspend_strand       (suspend),
        .resume_strand        (resume),
        .rollback_strand      (rollback),
        .issue_oh             (issue_oh),
        .strand_running       (strand_running),
        .all_blocked          (all_blocked)
    );

    function automatic bit m_eligible(int i);
        return !m_susp[i] && m_rb[i] == 0 && valid[i] && enable[i] &&
               !hazard[i] && !rollback[i];
    endfunction

    function automatic int m_winner();
        for (int k = 1; k <= 4; k++)
            if (m_eligible((m_lg + k) % 4)) return (m_lg + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_issue();
        int w;
        logic [3:0] v;
        v = 4'b0000;
        w = m_winner();
        if (!stall && w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] m_running();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = !m_susp[i] && m_rb[i] == 0;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%b expected=%b", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_susp[i] = 1'b0;
            m_rb[i]   = 0;
        end
        m_lg = 3;
    endtask

    task automatic model_check();
        cmp("model_issue_oh", issue_oh, m_issue());
        cmp("model_strand_running", strand_running, m_running());
        cmp("model_all_blocked", {3'b000, all_blocked},
            {3'b000, (m_winner() < 0) && !stall});
    endtask

    // Model advances on the rising edge and is compared on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
                if (!clk) model_check();
            end else if (clk) begin
                int w;
                w = m_winner();
                if (!stall && w >= 0) m_lg = w;
                for (int i = 0; i < 4; i++) begin
                    if (rollback[i]) begin
                        m_rb[i]   = 2;
                        m_susp[i] = 1'b0;
                    end else if (m_rb[i] > 0) begin
                        m_rb[i]--;
                    end else if (m_susp[i]) begin
                        if (resume[i]) m_susp[i] = 1'b0;
                    end else if (suspend[i] && !resume[i]) begin
                        m_susp[i] = 1'b1;
                    end
                end
            end else begin
                model_check();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation sampled 2 time units after inputs settle.
    task automatic lit(input string nm, input logic [3:0] exp_issue);
        #2;
        cmp(nm, issue_oh, exp_issue);
    endtask

    initial begin
        reset_n = 1'b0;
        valid = 4'b0; hazard = 4'b0; enable = 4'b1111;
        suspend = 4'b0; resume = 4'b0; rollback = 4'b0; stall = 1'b0;
        tick();
        #2 cmp("reset_running", strand_running, 4'b1111);
        tick();
        reset_n = 1'b1;

        // Rotation from strand 0 after reset
        valid = 4'b1111;
        lit("rr0", 4'b0001); tick();
        lit("rr1", 4'b0010); tick();
        lit("rr2", 4'b0100); tick();
        lit("rr3", 4'b1000); tick();
        lit("rr4", 4'b0001); tick();

        // Strands 1 and 3, hazard redirect
        valid = 4'b0010; lit("set_lg1", 4'b0010); tick();
        valid = 4'b1010; lit("s13_a", 4'b1000); tick();
        hazard = 4'b0010; lit("s13_hazard", 4'b1000); tick();
        hazard = 4'b0000; lit("s13_b", 4'b0010); tick();
        lit("s13_c", 4'b1000); tick();

        // Suspend / resume of strand 2
        valid = 4'b0100; suspend = 4'b0100;
        lit("susp_T", 4'b0100); tick();
        suspend = 4'b0000;
        lit("susp_T1", 4'b0000);
        cmp("susp_running", strand_running, 4'b1011);
        cmp("susp_blocked", {3'b000, all_blocked}, 4'b0001);
        tick();
        lit("susp_T2", 4'b0000); tick();
        resume = 4'b0100; lit("susp_T3", 4'b0000); tick();
        resume = 4'b0000; lit("resume_T4", 4'b0100); tick();

        // Simultaneous suspend and resume keeps strand 0 running
        valid = 4'b0001; suspend = 4'b0001; resume = 4'b0001;
        lit("sr_same", 4'b0001); tick();
        suspend = 4'b0000; resume = 4'b0000;
        #2 cmp("sr_running", strand_running, 4'b1111);
        tick();

        // Rollback of strand 3
        valid = 4'b1000; rollback = 4'b1000;
        lit("rb_T", 4'b0000); tick();
        rollback = 4'b0000;
        lit("rb_T1", 4'b0000);
        cmp("rb_running", strand_running, 4'b0111);
        tick();
        lit("rb_T2", 4'b0000); tick();
        lit("rb_T3", 4'b1000); tick();

        // Second rollback one cycle later extends the window
        rollback = 4'b1000; lit("rb2_T", 4'b0000); tick();
        lit("rb2_T1", 4'b0000); tick();
        rollback = 4'b0000; lit("rb2_T2", 4'b0000); tick();
        lit("rb2_T3", 4'b0000); tick();
        lit("rb2_T4", 4'b1000); tick();

        // Stall holds last_grant
        valid = 4'b1111; lit("pre_stall", 4'b0001); tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            lit("stall", 4'b0000);
            cmp("stall_blocked", {3'b000, all_blocked}, 4'b0000);
            tick();
        end
        stall = 1'b0;
        lit("post_stall", 4'b0010); tick();
        lit("post_stall2", 4'b0100); tick();

        // Reset pulse mid-sequence
        reset_n = 1'b0;
        #2 cmp("mid_reset_running", strand_running, 4'b1111);
        tick();
        reset_n = 1'b1;
        lit("post_reset", 4'b0001); tick();

        // Software enable mask
        enable = 4'b1010; lit("enable_mask", 4'b0010); tick();
        enable = 4'b0000; lit("enable_none", 4'b0000);
        cmp("enable_blocked", {3'b000, all_blocked}, 4'b0001);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/strand_issue_arbiter.md
# strand_issue_arbiter

Selects which of the four hardware strands issues an instruction each cycle, feeding the one-hot issue vector consumed by the execute hazard detector and the decode stage. Tracks a small per-strand run state (running / suspended on cache miss / rollback recovery). Arbitrates round-robin among eligible strands, honouring the per-strand execute writeback hazard and a global pipeline stall.

## Interface
- No parameters; strand count is fixed at 4.
- clk  input  1  core clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_instruction_valid  input  4  strand N has a fetched instruction ready.
- execute_hazard  input  4  strand N's instruction would collide at the execute writeback mux; combinational from the hazard detector.
- strand_enable  input  4  software strand enable; 0 makes the strand ineligible.
- stall  input  1  downstream pipeline stall; no issue this cycle.
- suspend_strand  input  4  strand N missed in cache; put it to sleep.
- resume_strand  input  4  strand N's fill is complete; wake it.
- rollback_strand  input  4  strand N is being flushed; enter rollback recovery.
- issue_oh  output  4  one-hot issue grant (all zero = no issue); combinational.
- strand_running  output  4  registered; 1 when strand N is in RUNNING.
- all_blocked  output  1  combinational; 1 when no strand is eligible and stall is 0.

## Operation
- Per-strand state, 2 bits: RUNNING, SUSPENDED, RB_WAIT. RB_WAIT carries a 1-bit down counter.
- Transitions, evaluated per strand each cycle, highest priority first:
  - rollback_strand[N]=1 from any state: go to RB_WAIT with counter=1. A rollback arriving during RB_WAIT reloads the counter.
  - RB_WAIT: if counter=1, decrement to 0. If counter=0, go to RUNNING. The strand is ineligible for exactly 2 cycles after the rollback cycle.
  - RUNNING with suspend=1 and resume=0: go to SUSPENDED.
  - RUNNING with suspend=1 and resume=1: stay RUNNING (fill already landed).
  - SUSPENDED with resume=1: go to RUNNING. Suspend while SUSPENDED is ignored.
  - Resume while RUNNING is ignored.
- Eligibility requires all of: eligible[N] = state==RUNNING & if_instruction_valid[N] & strand_enable[N] & ~execute_hazard[N] & ~rollback_strand[N].
  - The same-cycle rollback mask is combinational.
  - A same-cycle suspend does NOT mask; the strand may still issue that cycle.
- Round-robin arbitration:
  - A 2-bit last_grant register holds the index of the last strand that issued.
  - Search order is last_grant+1, +2, +3, +4, modulo 4.
  - The first eligible strand in that order is granted.
- If stall=1: issue_oh=0 and last_grant holds. Strand state transitions still occur.
- When a grant is made, last_grant takes the granted index on the next edge. With no grant, last_grant holds.
- issue_oh always has at most one bit set.

## Timing
- Reset (reset_n=0, asynchronous):
  - all strands go to RUNNING and RB counters clear.
  - last_grant=3, so strand 0 has first priority.
  - strand_running=4'b1111.
  - issue_oh follows its inputs combinationally.
- issue_oh has zero-cycle latency from eligibility inputs. It must not depend combinationally on any output of this block's consumer other than execute_hazard, which is itself independent of issue_oh in the same cycle.
- State changes triggered by suspend, resume or rollback take effect on the next edge. strand_running reflects them one cycle later.
- Rollback at cycle T: the strand is ineligible in cycles T, T+1 and T+2, and eligible again in T+3.
- Wrap-around: with last_grant=3, the search starts at strand 0.
- Reset deasserted mid-operation: the first cycle after release arbitrates from strand 0.

## Test plan
- Reset, then all four strands valid and enabled, no hazard, no stall -> issue_oh = 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Strands 1 and 3 valid, last_grant=1 -> grant 1000, then 0010, then 1000; execute_hazard=0010 on the second of those cycles -> grant 1000 instead.
- suspend_strand=0100 with strand 2 the only valid strand at cycle T -> issue_oh=0100 at T. At T+1, issue_oh=0000, strand_running=1011 and all_blocked=1. resume_strand=0100 at T+3 -> issue_oh=0100 at T+4.
- Suspend and resume both 0001 in the same cycle while strand 0 is RUNNING -> strand 0 stays RUNNING and strand_running[0] stays 1.
- rollback_strand=1000 at T with only strand 3 valid -> issue_oh=0000 at T, T+1 and T+2, and 1000 at T+3. A second rollback at T+1 extends the blocked window through T+3.
- stall=1 for 3 cycles with all strands valid -> issue_oh=0000 throughout and last_grant is unchanged. Next grant after stall release is last_grant+1. reset_n pulsed low mid-sequence -> next grant is 0001.
